morse_key_classifier: RTL and testbench

Parametrised next-generation key-timing classifier for the Morse machine. It samples the raw key `button` and the `send` request, and can optionally debounce the key. It measures press and release durations in clock cycles and emits a one-cycle symbol pulse (dot, dash or send), plus letter-gap and word-gap markers. Downstream symbol assembly consumes these pulses directly.

---
 rtl/morse_key_classifier.sv | 209 ++++++++++++++++++++
 tb/tb_morse_key_classifier.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : morse_key_classifier
//  Purpose  : Key-timing classifier for the Morse machine. Synchronizes the
//             raw key and send request, optionally debounces the key,
//             measures press/release durations and emits one-cycle symbol
//             pulses (dot, dash, send) plus letter-gap and word-gap markers.
//  Ports    : clk        - single clock, rising edge
//             reset      - synchronous, active-high
//             button     - raw key (asynchronous, active-high)
//             send       - raw send request (asynchronous, rising edge event)
//             sym        - 00 none, 01 dot, 10 dash, 11 send
//             sym_valid  - one-cycle strobe qualifying sym
//             letter_end - one-cycle strobe when a letter gap elapses
//             word_end   - one-cycle strobe when a word gap elapses
//             key_active - high while the FSM is in PRESS
//  Config   : define MORSE_DEBOUNCE_EN to enable the key debouncer
//             (stability window of DEBOUNCE_CYCLES cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module morse_key_classifier #(
   parameter int CNT_W           = 16,
   parameter int DOT_MAX         = 20,
   parameter int LETTER_GAP      = 60,
   parameter int WORD_GAP        = 140,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button,
   input  logic       send,
   output logic [1:0] sym,
   output logic       sym_valid,
   output logic       letter_end,
   output logic       word_end,
   output logic       key_active
);

   // Elaboration-time guard against unsupported parameter combinations.
   generate
      if (DEBOUNCE_CYCLES < 1 || DOT_MAX < 1 || DOT_MAX >= LETTER_GAP ||
          LETTER_GAP >= WORD_GAP || WORD_GAP >= (2**CNT_W) - 1) begin : g_bad_cfg
         $error("morse_key_classifier: unsupported parameter combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] c_cnt_max    = '1;
   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_dot_max    = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] c_letter_gap = CNT_W'(LETTER_GAP);
   localparam logic [CNT_W-1:0] c_word_gap   = CNT_W'(WORD_GAP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRESS = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchronizers; snd_s3_q holds the previous synchronized send
   // level for rising-edge detection.
   // ---------------------------------------------------------------------
   logic btn_s1_q, btn_s2_q;
   logic snd_s1_q, snd_s2_q, snd_s3_q;
   logic key_q;
   logic send_rise;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         snd_s1_q <= 1'b0;
         snd_s2_q <= 1'b0;
         snd_s3_q <= 1'b0;
      end else begin
         btn_s1_q <= button;
         btn_s2_q <= btn_s1_q;
         snd_s1_q <= send;
         snd_s2_q <= snd_s1_q;
         snd_s3_q <= snd_s2_q;
      end
   end

   assign send_rise = snd_s2_q & ~snd_s3_q;

`ifdef MORSE_DEBOUNCE_EN
   // The key only follows the synchronized button after it has differed
   // from the current key for DEBOUNCE_CYCLES consecutive cycles.
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [DB_W-1:0] db_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_q    <= 1'b0;
         db_cnt_q <= '0;
      end else if (btn_s2_q == key_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         key_q    <= btn_s2_q;
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + 1'b1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) key_q <= 1'b0;
      else       key_q <= btn_s2_q;
   end
`endif

   // ---------------------------------------------------------------------
   // Classifier FSM
   // ---------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             send_pend_q, send_pend_d;
   logic [1:0]       sym_q, sym_d;
   logic             sym_valid_q, sym_valid_d;
   logic             letter_end_q, letter_end_d;
   logic             word_end_q, word_end_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         press_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         send_pend_q  <= 1'b0;
         sym_q        <= 2'b00;
         sym_valid_q  <= 1'b0;
         letter_end_q <= 1'b0;
         word_end_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         press_cnt_q  <= press_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         send_pend_q  <= send_pend_d;
         sym_q        <= sym_d;
         sym_valid_q  <= sym_valid_d;
         letter_end_q <= letter_end_d;
         word_end_q   <= word_end_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      press_cnt_d  = press_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      send_pend_d  = send_pend_q;
      sym_d        = 2'b00;
      sym_valid_d  = 1'b0;
      letter_end_d = 1'b0;
      word_end_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (key_q) begin
               state_d     = S_PRESS;
               press_cnt_d = c_one;
            end
         end
         S_PRESS: begin
            if (key_q) begin
               if (press_cnt_q != c_cnt_max) press_cnt_d = press_cnt_q + 1'b1;
            end else begin
               sym_valid_d = 1'b1;
               sym_d       = (press_cnt_q <= c_dot_max) ? 2'b01 : 2'b10;
               state_d     = S_GAP;
               gap_cnt_d   = c_one;
            end
         end
         S_GAP: begin
            // The letter gap counts as reached on the cycle the counter holds
            // LETTER_GAP, even if the key comes back on that same cycle.
            if (gap_cnt_q == c_letter_gap) letter_end_d = 1'b1;
            if (key_q) begin
               state_d     = S_PRESS;
               press_cnt_d = c_one;
            end else if (gap_cnt_q == c_word_gap) begin
               word_end_d = 1'b1;
               state_d    = S_IDLE;
            end else if (gap_cnt_q != c_cnt_max) begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Send is deferred while in PRESS (including the release cycle that
      // emits the dot/dash) and released on the first cycle outside PRESS.
      // Repeated edges while pending collapse into one send symbol.
      if (state_q == S_PRESS) begin
         if (send_rise) send_pend_d = 1'b1;
      end else if (send_rise || send_pend_q) begin
         sym_valid_d = 1'b1;
         sym_d       = 2'b11;
         send_pend_d = 1'b0;
      end
   end

   assign sym        = sym_q;
   assign sym_valid  = sym_valid_q;
   assign letter_end = letter_end_q;
   assign word_end   = word_end_q;
   assign key_active = (state_q == S_PRESS);

endmodule
`default_nettype wire

// File: tb/tb_morse_key_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_key_classifier
//  Purpose  : Directed self-checking bench for morse_key_classifier with
//             default parameters. Key latency depends on MORSE_DEBOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morse_key_classifier;

   logic       clk = 1'b0;
   logic       reset;
   logic       button;
   logic       send;
   logic [1:0] sym;
   logic       sym_valid;
   logic       letter_end;
   logic       word_end;
   logic       key_active;

`ifdef MORSE_DEBOUNCE_EN
   localparam int KL = 6;   // button-to-key edges with a 4-cycle debounce
`else
   localparam int KL = 3;   // button-to-key edges through synchronizer + key reg
`endif

   morse_key_classifier dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
      .send       (send),
      .sym        (sym),
      .sym_valid  (sym_valid),
      .letter_end (letter_end),
      .word_end   (word_end),
      .key_active (key_active)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_sym   = 0;
   int n_let   = 0;
   int n_word  = 0;
   int n_bad_idle = 0;

   // Strobe tallies, sampled away from the active edge.
   always @(negedge clk) begin
      if (sym_valid === 1'b1)  n_sym++;
      if (letter_end === 1'b1) n_let++;
      if (word_end === 1'b1)   n_word++;
      if (sym_valid !== 1'b1 && sym !== 2'b00) n_bad_idle++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wait_sym(output int k);
      k = 0;
      while (sym_valid !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
   endtask

   // Hold the button n cycles, then expect one symbol KL+1 edges later.
   task automatic press_expect(input int n, input int exp_sym, input string tag);
      int k;
      int s0;
      s0 = n_sym;
      button = 1'b1;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (i == KL + 1) check({tag, " key_active"}, int'(key_active), 1);
      end
      button = 1'b0;
      wait_sym(k);
      check({tag, " latency"}, k, KL + 1);
      check({tag, " sym"}, int'(sym), exp_sym);
      check({tag, " early strobes"}, n_sym - s0, 0);
   endtask

   task automatic settle();
      repeat (160) tick();
   endtask

   initial begin
      int k;
      int s0;
      int l0;
      int w0;

      reset  = 1'b1;
      button = 1'b0;
      send   = 1'b0;
      repeat (3) tick();
      check("reset outputs", int'({sym, sym_valid, letter_end, word_end, key_active}), 0);
      check("reset state", int'(dut.state_q), 0);
      reset = 1'b0;
      tick();

      // Dot/dash boundary and saturation
      press_expect(20, 1, "press20");
      settle();
      press_expect(21, 2, "press21");
      settle();
      press_expect(70000, 2, "press_sat");
      settle();

      // Letter and word gap strobes
      press_expect(5, 1, "gap dot");
      k = 0;
      while (letter_end !== 1'b1 && k < 400) begin tick(); k++; end
      check("letter_end delay", k, 60);
      k = 0;
      while (word_end !== 1'b1 && k < 400) begin tick(); k++; end
      check("word_end delay", k + 60, 140);
      check("idle after word", int'(dut.state_q), 0);
      settle();

      // Re-press seen while the gap counter holds 59: no gap strobes
      press_expect(5, 1, "rp first");
      l0 = n_let;
      w0 = n_word;
      repeat (58 - KL) tick();
      press_expect(5, 1, "rp second");
      check("rp letter_end", n_let - l0, 0);
      check("rp word_end", n_word - w0, 0);
      settle();

      // Send from IDLE
      s0 = n_sym;
      send = 1'b1;
      wait_sym(k);
      check("send latency", k, 3);
      check("send sym", int'(sym), 3);
      send = 1'b0;
      repeat (5) tick();
      check("send count", n_sym - s0, 1);
      settle();

      // Two send edges during a press: dot first, then a single 11
      s0 = n_sym;
      button = 1'b1;
      repeat (KL + 2) tick();
      send = 1'b1;
      repeat (2) tick();
      send = 1'b0;
      repeat (2) tick();
      send = 1'b1;
      repeat (2) tick();
      send = 1'b0;
      repeat (6) tick();
      button = 1'b0;
      wait_sym(k);
      check("coll dot latency", k, KL + 1);
      check("coll dot sym", int'(sym), 1);
      check("coll strobes in press", n_sym - s0, 0);
      tick();
      check("coll send follows", int'({sym_valid, sym}), 7);
      repeat (10) tick();
      check("coll total syms", n_sym - s0, 2);
      settle();

      // Short glitch on the key
`ifdef MORSE_DEBOUNCE_EN
      s0 = n_sym;
      button = 1'b1;
      repeat (3) tick();
      button = 1'b0;
      repeat (20) tick();
      check("glitch filtered", n_sym - s0, 0);
`else
      button = 1'b1;
      tick();
      button = 1'b0;
      wait_sym(k);
      check("glitch latency", k, 4);
      check("glitch sym", int'(sym), 1);
`endif
      settle();

      // Reset mid-press: aborted press discarded, fresh press is a dash
      s0 = n_sym;
      button = 1'b1;
      repeat (15) tick();
      reset = 1'b1;
      tick();
      check("mid reset outputs a", int'({sym, sym_valid, letter_end, word_end, key_active}), 0);
      tick();
      check("mid reset outputs b", int'({sym, sym_valid, letter_end, word_end, key_active}), 0);
      reset = 1'b0;
      repeat (28) tick();
      button = 1'b0;
      wait_sym(k);
      check("post reset latency", k, KL + 1);
      check("post reset sym", int'(sym), 2);
      tick();
      check("post reset count", n_sym - s0, 1);
      settle();

      check("sym zero when idle", n_bad_idle, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
